load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU in the core datapath.
- Uses the ALU result as the effective byte address and performs LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a word-wide request/acknowledge memory bus, stalls the core until the access completes, and returns a sign- or zero-extended load result.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: maximum cycles in BUS waiting for mem_ack before a timeout fault; legal range 1..255.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- Start  in  1  access request from the core, sampled only in IDLE
- MemWrite  in  1  1 = store, 0 = load
- Funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads only for BU/HU)
- ALUResult  in  32  effective byte address from the ALU
- WriteData  in  32  store data, least-significant bits used for B/H
- ReadData  out  32  formatted load result, valid while Done=1
- Stall  out  1  holds the core's PC/pipeline
- Done  out  1  one-cycle completion pulse
- Fault  out  2  00 none, 01 misaligned/illegal Funct3, 10 timeout; valid while Done=1
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address, {ALUResult[31:2],2'b00}
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  bus read data, valid with mem_ack
- mem_ack  in  1  bus completion

Behaviour:
- Reset (async, immediate): state=IDLE, timeout counter=0, all outputs 0 (ReadData, Fault, mem_* = 0), mem_req=0.
  - Reset mid-transaction drops mem_req at once.
  - A late mem_ack after reset is ignored.
- States: IDLE, BUS, RESP.
- IDLE, Start=0: stay; Stall=0.
- IDLE, Start=1, access legal: latch MemWrite, Funct3, byte offset ALUResult[1:0], mem_addr, mem_wstrb, mem_wdata; go to BUS. Stall=1 combinationally in this cycle.
- Illegal access: H/HU with ALUResult[0]=1, W with ALUResult[1:0]!=0, Funct3 in {011,110,111}, or a store with Funct3 in {100,101}.
  - Go to RESP with Fault=01 and no bus request.
  - Stall=1 in the Start cycle.
- BUS:
  - mem_req=1; mem_we, mem_addr, mem_wstrb, mem_wdata held stable until ack.
  - Stall=1. The counter increments each cycle.
  - mem_ack=1: for loads, register the formatted mem_rdata into ReadData; go to RESP with Fault=00.
  - Counter reaching TIMEOUT with no ack: go to RESP with Fault=10 and ReadData=0.
  - mem_ack in the same cycle as the counter reaching TIMEOUT: ack wins.
- RESP:
  - Done=1 and Stall=0 for exactly one cycle; Fault and ReadData are valid; mem_req=0; then go to IDLE.
  - The counter clears.
  - Start is ignored in RESP (the core advances this cycle).
- Start outside IDLE is ignored. Inputs are not re-sampled during BUS.
- Latency: legal access with ack in the first BUS cycle means Done 2 cycles after the Start edge. Fault=01 means Done 1 cycle after the Start edge.
- Store formatting:
  - B: wstrb = 0001 << off; wdata = {4{WriteData[7:0]}}.
  - H: wstrb = 0011 << off; wdata = {2{WriteData[15:0]}}.
  - W: wstrb = 1111; wdata = WriteData.
  - Loads: wstrb = 0000.
- Load formatting:
  - Select byte/half at the latched offset.
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
- ReadData holds its value until the next load completes. It is 0 after a store completion or a fault.

Decomposition:
- Shared package core_pkg:
  - Funct3 encodings (F3_B/H/W/BU/HU)
  - Fault codes (FLT_NONE/MISALIGN/TIMEOUT)
  - The LSU state enumeration
- Sub-module: one combinational lsu_load_align (offset + Funct3 + rdata -> 32-bit extended result), reused by any later pipelined core.
- The store lane formatting stays inline.

Test Plan:
- Reset, then SW: ALUResult=0x100, WriteData=0xDEADBEEF, ack in the first BUS cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; Done 2 cycles after Start; Fault=00; Stall high for 2 cycles.
- LB at 0x203 with rdata=0x80FF_7F01 -> mem_addr=0x200, ReadData=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH at 0x102 with rdata=0x8001_1234 -> ReadData=0xFFFF8001. SH at 0x102 with WriteData=0xABCD -> wstrb=1100, wdata=0xABCDABCD.
- LW at 0x101 -> no mem_req ever; Done 1 cycle after Start; Fault=01; ReadData=0.
- LW with TIMEOUT=4 and ack never asserted -> mem_req high exactly 4 cycles, then Done with Fault=10. A repeat run with ack on cycle 4 -> Fault=00 (ack wins).
- Assert reset in the 2nd BUS cycle with ack arriving the next cycle -> mem_req=0 immediately, state IDLE, no Done pulse; the following Start works normally.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared Funct3 encodings, fault codes and LSU states for the core datapath.
package core_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
    localparam logic [1:0] LSU_IDLE = 2'b00;
    localparam logic [1:0] LSU_BUS  = 2'b01;
    localparam logic [1:0] LSU_RESP = 2'b10;
    // Undefined Funct3, unsigned stores, and halves/words off their natural alignment.
    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || (we && f3[2]) ||
               (f3[1:0] == 2'b01 && off[0]) || (f3 == F3_W && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the byte/half at the offset and sign- or zero-extends it.
module lsu_load_align
    import core_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);
    logic [31:0] sh;
    assign sh = rdata_i >> {off_i, 3'b000};
    always_comb
        result_o = funct3_i == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                   funct3_i == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                   funct3_i == F3_BU ? {24'd0, sh[7:0]} :
                   funct3_i == F3_HU ? {16'd0, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a req/ack word bus,
// stalling the core until completion and flagging misalignment and bus timeouts.
module load_store_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic [1:0]  Fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    logic [1:0]  state_q, state_d, off_q, off_d, fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, load_val;

    lsu_load_align u_align (
        .off_i   (off_q),
        .funct3_i(f3_q),
        .rdata_i (mem_rdata),
        .result_o(load_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        if (state_q == LSU_IDLE) begin
            if (Start && lsu_illegal(MemWrite, Funct3, ALUResult[1:0])) begin
                state_d = LSU_RESP;
                fault_d = FLT_MISALIGN;
                rdata_d = 32'd0;
            end else if (Start) begin
                state_d = LSU_BUS;
                we_d    = MemWrite;
                f3_d    = Funct3;
                off_d   = ALUResult[1:0];
                addr_d  = {ALUResult[31:2], 2'b00};
                wstrb_d = !MemWrite ? 4'b0000 :
                          Funct3[1:0] == 2'b00 ? 4'b0001 << ALUResult[1:0] :
                          Funct3[1:0] == 2'b01 ? 4'b0011 << ALUResult[1:0] : 4'b1111;
                wdata_d = Funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}} :
                          Funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
            end
        end else if (state_q == LSU_BUS) begin
            cnt_d = cnt_q + 8'd1;
            // Ack beats a timeout landing in the same cycle.
            if (mem_ack) begin
                state_d = LSU_RESP;
                fault_d = FLT_NONE;
                rdata_d = we_q ? 32'd0 : load_val;
            end else if (cnt_d == TIMEOUT[7:0]) begin
                state_d = LSU_RESP;
                fault_d = FLT_TIMEOUT;
                rdata_d = 32'd0;
            end
        end else begin
            state_d = LSU_IDLE;
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LSU_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= FLT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign mem_req   = state_q == LSU_BUS;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign Done      = state_q == LSU_RESP;
    assign Stall     = mem_req || (state_q == LSU_IDLE && Start);
    assign ReadData  = rdata_q;
    assign Fault     = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench driving the LSU through loads, stores, faults and reset.
module tb_load_store_unit;
    logic        clk = 1'b0, reset = 1'b1, Start = 1'b0, MemWrite = 1'b0, mem_ack = 1'b0;
    logic [2:0]  Funct3 = 3'd0;
    logic [31:0] ALUResult = 32'd0, WriteData = 32'd0, mem_rdata = 32'd0;
    logic [31:0] ReadData, mem_addr, mem_wdata;
    logic        Stall, Done, mem_req, mem_we;
    logic [1:0]  Fault;
    logic [3:0]  mem_wstrb;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  flt;
        int          lat;
    } exp_t;
    exp_t sb_q[$];
    int checks = 0, errors = 0, cyc = 0, start_cyc = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MemWrite(MemWrite), .Funct3(Funct3),
        .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .Done(Done), .Fault(Fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && Done) begin
            if (sb_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_rdata", ReadData, e.rd);
                check("done_fault", {30'd0, Fault}, {30'd0, e.flt});
                check("done_latency", cyc - start_cyc, e.lat);
                check("done_stall", {31'd0, Stall}, 32'd0);
            end
        end
    end

    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_at, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_rd, input logic [1:0] e_flt, input int e_lat,
                          input int e_req);
        int nreq, nstall;
        bit done;
        @(negedge clk);
        Start = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = addr; WriteData = wd;
        sb_q.push_back('{rd: e_rd, flt: e_flt, lat: e_lat});
        start_cyc = cyc;
        #1;
        check({tag, " stall_start"}, {31'd0, Stall}, 32'd1);
        nstall = 1; nreq = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            Start = 1'b0; MemWrite = ~we; Funct3 = 3'b111;
            ALUResult = $urandom; WriteData = $urandom;
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    check({tag, " addr"}, mem_addr, {addr[31:2], 2'b00});
                    check({tag, " we"}, {31'd0, mem_we}, {31'd0, we});
                    check({tag, " wstrb"}, {28'd0, mem_wstrb}, {28'd0, e_strb});
                    if (we) check({tag, " wdata"}, mem_wdata, e_wdata);
                end
                if (nreq == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rd;
                end
            end
            #1;
            if (Done) done = 1;
            else if (Stall) nstall++;
        end
        check({tag, " completed"}, {31'd0, done}, 32'd1);
        check({tag, " req_cycles"}, nreq, e_req);
        check({tag, " stall_cycles"}, nstall, e_lat);
        @(negedge clk);
        mem_ack = 1'b0;
        check({tag, " done_once"}, {31'd0, Done}, 32'd0);
        check({tag, " rdata_hold"}, ReadData, e_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst ReadData", ReadData, 32'd0);
        check("rst Fault", {30'd0, Fault}, 32'd0);
        check("rst Stall", {31'd0, Stall}, 32'd0);
        check("rst Done", {31'd0, Done}, 32'd0);
        check("rst mem_req", {31'd0, mem_req}, 32'd0);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        access("SW",  1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 2'b00, 2, 1);
        access("LB",  0, 3'b000, 32'h203, 32'h0, 32'h80FF7F01, 1, 4'b0000, 32'h0, 32'hFFFFFF80, 2'b00, 2, 1);
        access("LBU", 0, 3'b100, 32'h203, 32'h0, 32'h80FF7F01, 1, 4'b0000, 32'h0, 32'h00000080, 2'b00, 2, 1);
        access("LH",  0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1, 4'b0000, 32'h0, 32'hFFFF8001, 2'b00, 2, 1);
        access("LHU", 0, 3'b101, 32'h102, 32'h0, 32'h80011234, 2, 4'b0000, 32'h0, 32'h00008001, 2'b00, 3, 2);
        access("SH",  1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1, 4'b1100, 32'hABCDABCD, 32'h0, 2'b00, 2, 1);
        access("SB",  1, 3'b000, 32'h301, 32'h1234565A, 32'h0, 3, 4'b0010, 32'h5A5A5A5A, 32'h0, 2'b00, 4, 3);
        access("LB0", 0, 3'b000, 32'h200, 32'h0, 32'h80FF7F01, 1, 4'b0000, 32'h0, 32'h00000001, 2'b00, 2, 1);
        access("LWmis", 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);
        access("LHmis", 0, 3'b001, 32'h103, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);
        access("SBU", 1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);
        access("F3_011", 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0, 2'b01, 1, 0);
        access("LWto", 0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 2'b10, 5, 4);
        access("LWack4", 0, 3'b010, 32'h400, 32'h0, 32'h12345678, 4, 4'b0000, 32'h0, 32'h12345678, 2'b00, 5, 4);

        // Reset in the second BUS cycle, with a stale ack arriving afterwards.
        @(negedge clk);
        Start = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300;
        @(negedge clk);
        Start = 1'b0;
        check("rstbus req1", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        check("rstbus req2", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("rstbus req_drop", {31'd0, mem_req}, 32'd0);
        check("rstbus stall", {31'd0, Stall}, 32'd0);
        check("rstbus addr", mem_addr, 32'd0);
        check("rstbus rdata", ReadData, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstbus no_done", {31'd0, Done}, 32'd0);
        check("rstbus idle_req", {31'd0, mem_req}, 32'd0);
        check("rstbus rdata_after", ReadData, 32'd0);
        @(negedge clk);
        check("rstbus no_done2", {31'd0, Done}, 32'd0);

        access("LBpost", 0, 3'b000, 32'h202, 32'h0, 32'h80FF7F01, 2, 4'b0000, 32'h0, 32'hFFFFFFFF, 2'b00, 3, 2);
        access("SWpost", 1, 3'b010, 32'h500, 32'hA5A5_0F0F, 32'h0, 1, 4'b1111, 32'hA5A50F0F, 32'h0, 2'b00, 2, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
